// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction fetch/decode sequencer driving Y-register bus controller strobes
module control_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      instr,
    input  logic            z_flag,
    output logic            iram_rd,
    output logic [PC_W-1:0] pc,
    output logic            read,
    output logic            DR_out,
    output logic [2:0]      reg_addr,
    output logic            y_we,
    output logic            ac_load,
    output logic            dram_rd,
    output logic            dram_wr,
    output logic            dr_load,
    output logic            alu_en,
    output logic [2:0]      alu_op,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_RDY   = 4'h1;
    localparam logic [3:0] OP_WRY   = 4'h2;
    localparam logic [3:0] OP_LDDR  = 4'h3;
    localparam logic [3:0] OP_STDR  = 4'h4;
    localparam logic [3:0] OP_DROUT = 4'h5;
    localparam logic [3:0] OP_ALU   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JMPZ  = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_MEM,
        S_OPWAIT,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      opcode;
    logic [2:0]      operand;
    logic            op_undefined;
    logic [PC_W-1:0] pc_inc;
    logic            unused_ir_bit;

    assign opcode        = ir_q[7:4];
    assign operand       = ir_q[2:0];
    assign unused_ir_bit = ir_q[3];
    assign pc_inc        = pc_q + PC_W'(1);

    // opcodes 0x9..0xE have no meaning and are flagged as illegal
    assign op_undefined = (opcode >= 4'h9) && (opcode <= 4'hE);

    // state, program counter, instruction register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= 8'h00;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // next-state and register update logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ir_d    = instr;
                pc_d    = pc_inc;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_undefined) begin
                    illegal_d = 1'b1;
                end
                case (opcode)
                    OP_LDDR:         state_d = S_MEM;
                    OP_JMP, OP_JMPZ: state_d = S_OPWAIT;
                    OP_HALT:         state_d = S_HALT;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                state_d = S_FETCH;
            end
            S_OPWAIT: begin
                // the operand byte sits on instr now; a jump not taken skips over it
                if ((opcode == OP_JMP) || z_flag) begin
                    pc_d = PC_W'(instr);
                end else begin
                    pc_d = pc_inc;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // output decode from state and IR only, so no input reaches an output combinationally
    always_comb begin
        iram_rd  = 1'b0;
        read     = 1'b0;
        DR_out   = 1'b0;
        reg_addr = 3'd0;
        y_we     = 1'b0;
        ac_load  = 1'b0;
        dram_rd  = 1'b0;
        dram_wr  = 1'b0;
        dr_load  = 1'b0;
        alu_en   = 1'b0;
        alu_op   = 3'd0;
        done     = 1'b0;
        case (state_q)
            S_FETCH: begin
                iram_rd = 1'b1;
            end
            S_EXEC: begin
                case (opcode)
                    OP_NOP: begin
                    end
                    OP_RDY: begin
                        read     = 1'b1;
                        reg_addr = operand;
                        ac_load  = 1'b1;
                    end
                    OP_WRY: begin
                        // bus left undriven by Y/DR so the write source is the other bus master
                        reg_addr = operand;
                        y_we     = 1'b1;
                    end
                    OP_LDDR: begin
                        dram_rd = 1'b1;
                    end
                    OP_STDR: begin
                        dram_wr = 1'b1;
                    end
                    OP_DROUT: begin
                        DR_out  = 1'b1;
                        ac_load = 1'b1;
                    end
                    OP_ALU: begin
                        alu_en = 1'b1;
                        alu_op = operand;
                    end
                    OP_JMP, OP_JMPZ: begin
                        // pc already points at the operand byte
                        iram_rd = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                dr_load = 1'b1;
            end
            S_HALT: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc      = pc_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] instr = 8'h00;
    logic       z_flag;
    logic       iram_rd;
    logic [7:0] pc;
    logic       read, DR_out, y_we, ac_load, dram_rd, dram_wr, dr_load, alu_en;
    logic [2:0] reg_addr, alu_op;
    logic       busy, done, illegal;

    control_sequencer #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .z_flag(z_flag),
        .iram_rd(iram_rd), .pc(pc), .read(read), .DR_out(DR_out),
        .reg_addr(reg_addr), .y_we(y_we), .ac_load(ac_load),
        .dram_rd(dram_rd), .dram_wr(dram_wr), .dr_load(dr_load),
        .alu_en(alu_en), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // synchronous instruction RAM
    logic [7:0] mem [256];
    always @(posedge clk) if (iram_rd) instr <= mem[pc];

    localparam logic [7:0] B_READ  = 8'h80;
    localparam logic [7:0] B_DROUT = 8'h40;
    localparam logic [7:0] B_YWE   = 8'h20;
    localparam logic [7:0] B_AC    = 8'h10;
    localparam logic [7:0] B_DRD   = 8'h08;
    localparam logic [7:0] B_DWR   = 8'h04;
    localparam logic [7:0] B_DRL   = 8'h02;
    localparam logic [7:0] B_ALU   = 8'h01;

    typedef struct {
        int         cyc;
        logic [7:0] strb;
        logic [2:0] ra;
        logic [2:0] op;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  mcyc  = 0;
    int  tcyc  = 0;

    wire [7:0] strb = {read, DR_out, y_we, ac_load, dram_rd, dram_wr, dr_load, alu_en};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_ev(input int c, input logic [7:0] s, input logic [2:0] ra, input logic [2:0] op);
        ev_t e;
        e.cyc = c; e.strb = s; e.ra = ra; e.op = op;
        exp_q.push_back(e);
    endtask

    // monitor: pops one expected event whenever any strobe is active
    always @(negedge clk) begin : monitor
        ev_t e;
        if (start && !busy) mcyc = 0;
        else mcyc++;
        chk("rd_drout_excl", {31'd0, read & DR_out}, 32'd0);
        if (y_we) chk("ywe_bus_idle", {30'd0, read, DR_out}, 32'd0);
        if (strb != 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {24'd0, strb}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_cycle", mcyc, e.cyc);
                chk("ev_strobes", {24'd0, strb}, {24'd0, e.strb});
                if ((e.strb & (B_READ | B_YWE)) != 8'h00) chk("ev_reg_addr", {29'd0, reg_addr}, {29'd0, e.ra});
                if ((e.strb & B_ALU) != 8'h00) chk("ev_alu_op", {29'd0, alu_op}, {29'd0, e.op});
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic start_prog();
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        tcyc = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (tcyc < n) begin
            @(negedge clk);
            tcyc++;
        end
    endtask

    task automatic wait_done(input string name, input int exp_cyc, input logic [7:0] exp_pc);
        int k;
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            tcyc++;
            k++;
        end
        if (!done) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_done_cycle"}, tcyc, exp_cyc);
            chk({name, "_halt_pc"}, {24'd0, pc}, {24'd0, exp_pc});
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
        chk({name, "_pc"}, {24'd0, pc}, 32'd0);
        chk({name, "_strobes"}, {23'd0, iram_rd, strb}, 32'd0);
        chk({name, "_reg_addr"}, {29'd0, reg_addr}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; z_flag = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;

        // reset asserted while WRY 3 is executing
        mem[0] = 8'h23; mem[1] = 8'hF0;
        push_ev(3, B_YWE, 3'd3, 3'd0);
        start_prog();
        wait_cyc(3);
        chk("wry_ywe_before_rst", {31'd0, y_we}, 32'd1);
        rst = 1'b1;
        wait_cyc(4);
        chk_quiet("rst_mid");
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(6);
        chk_quiet("rst_after");

        // straight-line
        clear_mem();
        mem[0] = 8'h13; mem[1] = 8'h25; mem[2] = 8'h62; mem[3] = 8'hF0;
        push_ev(3, B_READ | B_AC, 3'd3, 3'd0);
        push_ev(6, B_YWE, 3'd5, 3'd0);
        push_ev(9, B_ALU, 3'd0, 3'd2);
        start_prog();
        wait_done("straight", 13, 8'h04);
        chk("straight_illegal", {31'd0, illegal}, 32'd0);
        chk("straight_busy", {31'd0, busy}, 32'd0);

        // memory path
        clear_mem();
        mem[0] = 8'h30; mem[1] = 8'h50; mem[2] = 8'h40; mem[3] = 8'hF0;
        push_ev(3, B_DRD, 3'd0, 3'd0);
        push_ev(4, B_DRL, 3'd0, 3'd0);
        push_ev(7, B_DROUT | B_AC, 3'd0, 3'd0);
        push_ev(10, B_DWR, 3'd0, 3'd0);
        start_prog();
        wait_done("memory", 14, 8'h04);

        // JMPZ taken
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h10; mem[2] = 8'hF0; mem[8'h10] = 8'hF0;
        z_flag = 1'b1;
        start_prog();
        wait_cyc(3);
        chk("jmpz_exec_iram_rd", {31'd0, iram_rd}, 32'd1);
        wait_cyc(5);
        chk("jmpz_taken_pc", {24'd0, pc}, 32'h10);
        wait_done("jmpz_taken", 8, 8'h11);

        // JMPZ not taken
        z_flag = 1'b0;
        start_prog();
        wait_cyc(5);
        chk("jmpz_fall_pc", {24'd0, pc}, 32'h02);
        wait_done("jmpz_fall", 8, 8'h03);

        // JMP at 0xFF: operand fetched from wrapped address 0x00
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'hFF; mem[8'hFF] = 8'h70; mem[8'h70] = 8'hF0;
        start_prog();
        wait_cyc(5);
        chk("wrap_fetch_pc", {24'd0, pc}, 32'hFF);
        wait_cyc(7);
        chk("wrap_operand_pc", {24'd0, pc}, 32'h00);
        chk("wrap_operand_rd", {31'd0, iram_rd}, 32'd1);
        wait_cyc(9);
        chk("wrap_target_pc", {24'd0, pc}, 32'h70);
        wait_done("wrap", 12, 8'h71);

        // illegal opcode, start while busy ignored, restart from HALT
        clear_mem();
        mem[0] = 8'hA0; mem[1] = 8'hF0;
        start_prog();
        wait_cyc(2);
        start = 1'b1;
        wait_cyc(3);
        start = 1'b0;
        wait_done("illegal", 7, 8'h02);
        chk("illegal_set", {31'd0, illegal}, 32'd1);
        start_prog();
        wait_cyc(1);
        chk("restart_pc", {24'd0, pc}, 32'h00);
        chk("restart_illegal_clr", {31'd0, illegal}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_done("restart", 7, 8'h02);
        chk("restart_illegal_set", {31'd0, illegal}, 32'd1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Upstream control stage for the Y-register bus controller.
- Fetches 8-bit instructions from a synchronous instruction RAM and decodes them. For each instruction it generates the `read` / `DR_out` / `reg_addr` triple that selects bus source or Y-register write enable, plus data-memory, DR-load, accumulator-load and ALU strobes.
- Sits between the instruction memory and the datapath of the down-sampling processor.

Parameters:
- PC_W, 8, program counter / instruction address width.

Ports:
- clk      input   1  system clock, all state updates on rising edge
- rst      input   1  synchronous active-high reset
- start    input   1  begin execution at address 0 (sampled in IDLE/HALT)
- instr    input   8  instruction RAM read data, valid the cycle after iram_rd
- z_flag   input   1  ALU zero flag, sampled in OPWAIT
- iram_rd  output  1  instruction RAM read strobe
- pc       output  PC_W  instruction RAM address (program counter)
- read     output  1  to bus controller: drive bus from Y register reg_addr
- DR_out   output  1  to bus controller: drive bus from DR
- reg_addr output  3  Y register select (R3..R10 = 0..7)
- y_we     output  1  qualifies enY; Y register write only when y_we=1
- ac_load  output  1  accumulator captures bus this cycle
- dram_rd  output  1  data memory read strobe
- dram_wr  output  1  data memory write strobe (DR -> memory)
- dr_load  output  1  DR captures data memory output
- alu_en   output  1  ALU executes alu_op this cycle
- alu_op   output  3  ALU function = IR[2:0]
- busy     output  1  1 in every state except IDLE and HALT
- done     output  1  1 while in HALT
- illegal  output  1  sticky: undefined opcode decoded since last start/reset

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, pc=0, IR=0x00, illegal=0. All strobes are 0, reg_addr=0, busy=0, done=0. Reset mid-instruction aborts immediately; no strobe is asserted in the cycle after reset.
- IR format: opcode=IR[7:4], operand=IR[2:0].
- Opcodes:
  - 0x0 NOP
  - 0x1 RDY r (read=1, reg_addr=r, ac_load=1)
  - 0x2 WRY r (read=0, DR_out=0, reg_addr=r, y_we=1)
  - 0x3 LDDR (dram_rd, then dr_load)
  - 0x4 STDR (dram_wr=1)
  - 0x5 DROUT (DR_out=1, ac_load=1)
  - 0x6 ALU (alu_en=1, alu_op=IR[2:0])
  - 0x7 JMP a (two-byte instruction; second byte is the target)
  - 0x8 JMPZ a (two-byte; jump if z_flag=1)
  - 0xF HALT
  - 0x9-0xE: executes as NOP and sets illegal.
- Outputs are decoded combinationally from state and IR only. No combinational path from any input to any output.
- read and DR_out are never both 1. y_we=1 only in EXEC of WRY, and only with read=DR_out=0.
- States and transitions:
  - IDLE: start=1 -> pc<=0, illegal<=0, go to FETCH.
  - FETCH: iram_rd=1 -> go to WAIT.
  - WAIT: IR<=instr, pc<=pc+1 -> go to EXEC.
  - EXEC: drive the instruction's strobes for exactly 1 cycle.
    - LDDR -> MEM.
    - JMP/JMPZ: iram_rd=1 at pc -> OPWAIT.
    - HALT -> HALT.
    - All other opcodes -> FETCH.
  - MEM: dr_load=1 -> FETCH.
  - OPWAIT: pc<=(JMP or z_flag) ? instr : pc+1 -> FETCH.
  - HALT: done=1, pc frozen; start=1 -> pc<=0, illegal<=0, FETCH.
- Latency:
  - 3 cycles for single-byte instructions.
  - 4 cycles for LDDR.
  - 4 cycles for JMP/JMPZ.
- pc arithmetic is modulo 2^PC_W: 0xFF+1 wraps to 0x00, including the operand fetch of a jump at 0xFF.
- start is ignored while busy=1.

Test Plan:
- Reset: assert rst 2 cycles mid-EXEC of WRY 3 -> next cycle state IDLE, pc=0, y_we=0, busy=0, all strobes 0.
- Straight-line: program {0x13, 0x25, 0x62, 0xF0}, start pulse. Required response:
  - RDY: read=1, reg_addr=3, ac_load=1 in cycle 3.
  - WRY: y_we=1, reg_addr=5, read=DR_out=0 in cycle 6.
  - ALU: alu_en=1, alu_op=2 in cycle 9.
  - HALT: done=1 from cycle 13 with pc=4.
- Memory: {0x30, 0x50, 0x40, 0xF0}. Required response:
  - LDDR: dram_rd 1 cycle, then dr_load exactly the next cycle.
  - DROUT: DR_out=1, ac_load=1, read=0.
  - STDR: dram_wr 1 cycle.
  - read and DR_out never both 1.
- Branch: {0x80, 0x10, 0xF0, ..., @0x10: 0xF0}.
  - z_flag=1 -> pc=0x10 after OPWAIT, halts with pc=0x11.
  - z_flag=0 -> pc=0x02, halts with pc=0x03.
  - JMP 0x00 at 0xFE/0xFF -> loops to 0, pc wrap exercised.
- Illegal/restart: {0xA0, 0xF0} -> illegal=1, no strobes during that EXEC, HALT. start pulse during busy ignored. start in HALT -> pc=0, illegal cleared, re-executes.
